// File: rtl/controller_fsm.sv
// controller_fsm: two-phase FETCH/EXECUTE control unit for the single-accumulator CPU datapath
module controller_fsm (
    input  logic       Clk,
    input  logic       reset,
    input  logic [3:0] Opcode,
    input  logic       Z,
    input  logic       C,
    output logic       LoadIR,
    output logic       IncPC,
    output logic       SelPC,
    output logic       LoadPC,
    output logic       LoadReg,
    output logic       LoadAcc,
    output logic [1:0] SelAcc,
    output logic [3:0] SelALU
);
    localparam logic [3:0] OP_NOP        = 4'b0000;
    localparam logic [3:0] OP_ADD        = 4'b0001;
    localparam logic [3:0] OP_SUB        = 4'b0010;
    localparam logic [3:0] OP_NOR        = 4'b0011;
    localparam logic [3:0] OP_REG_TO_ACC = 4'b0100;
    localparam logic [3:0] OP_ACC_TO_REG = 4'b0101;
    localparam logic [3:0] OP_JMPZ_REG   = 4'b0110;
    localparam logic [3:0] OP_JMPZ_IMM   = 4'b0111;
    localparam logic [3:0] OP_JMPC_REG   = 4'b1000;
    localparam logic [3:0] OP_JMPC_IMM   = 4'b1010;
    localparam logic [3:0] OP_SHFL       = 4'b1011;
    localparam logic [3:0] OP_SHFR       = 4'b1100;
    localparam logic [3:0] OP_IMM_TO_ACC = 4'b1101;
    localparam logic [3:0] OP_HALT       = 4'b1111;

    localparam logic [1:0] ACC_FROM_REG = 2'b01;
    localparam logic [1:0] ACC_FROM_IMM = 2'b10;

    typedef enum logic [1:0] {
        S_RESET  = 2'b00,
        S_FETCH  = 2'b01,
        S_EXEC   = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    state_t r_state;
    logic   w_taken;
    logic   w_imm_jump;

    // Z-conditioned jumps test Z, C-conditioned jumps test C; IMM forms load PC from the immediate
    assign w_taken    = (Opcode == OP_JMPZ_REG || Opcode == OP_JMPZ_IMM) ? Z : C;
    assign w_imm_jump = (Opcode == OP_JMPZ_IMM || Opcode == OP_JMPC_IMM);

    // Alternate fetch and execute; the unused encoding recovers into fetch
    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            r_state <= S_RESET;
        else
            r_state <= (r_state == S_FETCH) ? S_EXEC : S_FETCH;
    end

    // Strobes decode from the state, plus opcode and flags during execute only
    always_comb begin
        LoadIR  = 1'b0;
        IncPC   = 1'b0;
        SelPC   = 1'b0;
        LoadPC  = 1'b0;
        LoadReg = 1'b0;
        LoadAcc = 1'b0;
        SelAcc  = 2'b00;
        SelALU  = 4'b0000;
        if (r_state == S_FETCH)
            LoadIR = 1'b1;
        else if (r_state == S_EXEC) begin
            case (Opcode)
                OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR: begin
                    LoadAcc = 1'b1;
                    SelALU  = Opcode;
                    IncPC   = 1'b1;
                end
                OP_REG_TO_ACC: begin
                    LoadAcc = 1'b1;
                    SelAcc  = ACC_FROM_REG;
                    IncPC   = 1'b1;
                end
                OP_IMM_TO_ACC: begin
                    LoadAcc = 1'b1;
                    SelAcc  = ACC_FROM_IMM;
                    IncPC   = 1'b1;
                end
                OP_ACC_TO_REG: begin
                    LoadReg = 1'b1;
                    IncPC   = 1'b1;
                end
                OP_JMPZ_REG, OP_JMPZ_IMM, OP_JMPC_REG, OP_JMPC_IMM: begin
                    SelPC  = w_imm_jump;
                    LoadPC = w_taken;
                    IncPC  = ~w_taken;
                end
                OP_HALT: ;
                OP_NOP:  IncPC = 1'b1;
                default: IncPC = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_controller_fsm.sv
// tb_controller_fsm: randomized check of controller_fsm against a rule-level reference model
module tb_controller_fsm;
    logic       Clk;
    logic       reset;
    logic [3:0] Opcode;
    logic       Z;
    logic       C;
    logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic [11:0] w_outs;
    int n;
    int compared;
    int mismatched;

    controller_fsm dut (
        .Clk(Clk), .reset(reset), .Opcode(Opcode), .Z(Z), .C(C),
        .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU)
    );

    assign w_outs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    // Phase k counts rising edges since reset release: 0 = reset, odd = fetch, even = execute.
    function automatic logic [11:0] model(int k, logic [3:0] op, logic z, logic c);
        logic inc, sel_pc, ld_pc, ld_reg, ld_acc, cond;
        logic [1:0] sel_acc;
        logic [3:0] alu;
        inc = 0; sel_pc = 0; ld_pc = 0; ld_reg = 0; ld_acc = 0; sel_acc = 0; alu = 0;
        if (k == 0) return 12'h000;
        if (k % 2 == 1) return 12'h800;
        if (op inside {4'd1, 4'd2, 4'd3, 4'd11, 4'd12}) begin
            ld_acc = 1; alu = op; inc = 1;
        end else if (op == 4'd4) begin
            ld_acc = 1; sel_acc = 2'd1; inc = 1;
        end else if (op == 4'd13) begin
            ld_acc = 1; sel_acc = 2'd2; inc = 1;
        end else if (op == 4'd5) begin
            ld_reg = 1; inc = 1;
        end else if (op inside {4'd6, 4'd7, 4'd8, 4'd10}) begin
            cond   = (op == 4'd6 || op == 4'd7) ? z : c;
            sel_pc = (op == 4'd7 || op == 4'd10);
            ld_pc  = cond;
            inc    = !cond;
        end else if (op != 4'd15) begin
            inc = 1;
        end
        return {1'b0, inc, sel_pc, ld_pc, ld_reg, ld_acc, sel_acc, alu};
    endfunction

    task automatic step();
        @(posedge Clk);
        n = reset ? 0 : n + 1;
        #2;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            Opcode = 4'($urandom); Z = 1'($urandom); C = 1'($urandom);
            #1;
            compared++;
            if (w_outs !== 12'h000) begin
                mismatched++;
                $display("FAIL reset_hold: got %03h expected 000", w_outs);
            end
        end
        reset = 1'b0;
        n = 0;
        Opcode = 4'd1;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            e = model(n, Opcode, Z, C);
            compared++;
            if (w_outs !== e) begin
                mismatched++;
                $display("FAIL reset_release_%0d: got %03h expected %03h", i, w_outs, e);
            end
        end
    endtask

    task automatic run_op(string name, logic [3:0] op, int cycles);
        logic [11:0] e;
        for (int i = 0; i < cycles; i++) begin
            step();
            Opcode = op; Z = 1'($urandom); C = 1'($urandom);
            #1;
            e = model(n, Opcode, Z, C);
            compared++;
            if (w_outs !== e) begin
                mismatched++;
                $display("FAIL %s op=%b z=%b c=%b: got %03h expected %03h", name, op, Z, C, w_outs, e);
            end
        end
    endtask

    task automatic test_alu();
        run_op("alu_add", 4'b0001, 10);
        run_op("alu_sub", 4'b0010, 10);
        run_op("alu_nor", 4'b0011, 10);
        run_op("alu_shfr", 4'b1100, 10);
        run_op("alu_shfl", 4'b1011, 10);
    endtask

    task automatic test_moves();
        run_op("reg_to_acc", 4'b0100, 6);
        run_op("imm_to_acc", 4'b1101, 6);
        run_op("acc_to_reg", 4'b0101, 6);
    endtask

    task automatic test_jumps();
        run_op("jmpz_imm", 4'b0111, 16);
        run_op("jmpz_reg", 4'b0110, 16);
        run_op("jmpc_reg", 4'b1000, 16);
        run_op("jmpc_imm", 4'b1010, 16);
    endtask

    task automatic test_halt_nop();
        run_op("halt", 4'b1111, 8);
        run_op("unassigned", 4'b1001, 6);
        run_op("nop", 4'b0000, 6);
    endtask

    task automatic test_random();
        logic [11:0] e;
        for (int i = 0; i < 300; i++) begin
            step();
            Opcode = 4'($urandom); Z = 1'($urandom); C = 1'($urandom);
            #1;
            e = model(n, Opcode, Z, C);
            compared++;
            if (w_outs !== e) begin
                mismatched++;
                $display("FAIL random op=%b z=%b c=%b: got %03h expected %03h", Opcode, Z, C, w_outs, e);
            end
            compared++;
            if (IncPC && LoadPC) begin
                mismatched++;
                $display("FAIL inc_load_exclusive: got IncPC=1 LoadPC=1 required not both");
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        if (n % 2 == 1) step();
        Opcode = 4'b0001; Z = 1'b0; C = 1'b0;
        #1;
        e = model(n, Opcode, Z, C);
        compared++;
        if (w_outs !== e) begin
            mismatched++;
            $display("FAIL async_pre_exec: got %03h expected %03h", w_outs, e);
        end
        #1 reset = 1'b1;
        #1;
        compared++;
        if (w_outs !== 12'h000) begin
            mismatched++;
            $display("FAIL async_drop: got %03h expected 000", w_outs);
        end
        step();
        #1;
        compared++;
        if (w_outs !== 12'h000) begin
            mismatched++;
            $display("FAIL async_hold: got %03h expected 000", w_outs);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            e = model(n, Opcode, Z, C);
            compared++;
            if (w_outs !== e) begin
                mismatched++;
                $display("FAIL async_release_%0d: got %03h expected %03h", i, w_outs, e);
            end
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        n = 0;
        reset = 1'b1;
        Opcode = 4'd0; Z = 1'b0; C = 1'b0;
        test_reset();
        test_alu();
        test_moves();
        test_jumps();
        test_halt_nop();
        test_random();
        test_async_reset();
        run_op("post_reset_add", 4'b0001, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
